// File: rtl/alu_in_initiator.sv
// Driving end of the alu_in bus: buffers (op, a, b) commands in a small FIFO and replays them,
// turning rst_op commands into an active-low alu_rst pulse of RST_CYCLES cycles.
module alu_in_initiator #(
  parameter int unsigned ALU_IN_OP_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned RST_CYCLES      = 2,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic [ALU_IN_OP_WIDTH-1:0]     cmd_a,
  input  logic [ALU_IN_OP_WIDTH-1:0]     cmd_b,
  input  logic                           ready,
  output logic                           valid,
  output logic                           alu_rst,
  output logic [2:0]                     op,
  output logic [ALU_IN_OP_WIDTH-1:0]     a,
  output logic [ALU_IN_OP_WIDTH-1:0]     b,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [COUNT_WIDTH-1:0]         issue_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned EntW = 3 + 2 * ALU_IN_OP_WIDTH;
  localparam int unsigned PulW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [2:0]  OpRst = 3'd7;

  typedef enum logic [1:0] {StIdle, StIssue, StResetPulse} state_e;

  state_e                     state_q, state_d;
  logic [EntW-1:0]            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]            level_q, level_d;
  logic [PulW-1:0]            pulse_q, pulse_d;
  logic                       valid_d, alu_rst_d;
  logic [2:0]                 op_d;
  logic [ALU_IN_OP_WIDTH-1:0] a_d, b_d;
  logic [COUNT_WIDTH-1:0]     count_d;
  logic                       full, empty, push, pop;
  logic [EntW-1:0]            head;
  logic [2:0]                 head_op;

  assign full      = (level_q == LvlW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign push      = cmd_valid && !full;
  assign cmd_ready = !full;
  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[EntW-1 -: 3];
  assign busy      = !empty || (state_q != StIdle);
  assign fifo_level = level_q;

  // Storage needs no reset: occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LvlW'(1);
    else if (pop && !push) level_d = level_q - LvlW'(1);
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    valid_d   = 1'b0;
    alu_rst_d = alu_rst;
    op_d      = op;
    a_d       = a;
    b_d       = b;
    pulse_d   = pulse_q;
    count_d   = issue_count;
    case (state_q)
      StIdle: begin
        if (enable && !empty) begin
          // rst_op launches regardless of ready; normal ops wait for it.
          if (head_op == OpRst) begin
            pop       = 1'b1;
            op_d      = OpRst;
            a_d       = '0;
            b_d       = '0;
            alu_rst_d = 1'b0;
            pulse_d   = PulW'(RST_CYCLES - 1);
            state_d   = StResetPulse;
          end else if (ready) begin
            pop     = 1'b1;
            op_d    = head_op;
            a_d     = head[2*ALU_IN_OP_WIDTH-1 -: ALU_IN_OP_WIDTH];
            b_d     = head[ALU_IN_OP_WIDTH-1:0];
            valid_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        count_d = issue_count + COUNT_WIDTH'(1);
        state_d = StIdle;
      end
      StResetPulse: begin
        if (pulse_q == '0) begin
          alu_rst_d = 1'b1;
          count_d   = issue_count + COUNT_WIDTH'(1);
          state_d   = StIdle;
        end else begin
          pulse_d = pulse_q - PulW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pulse_q     <= '0;
      valid       <= 1'b0;
      alu_rst     <= 1'b1;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      issue_count <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      valid       <= valid_d;
      alu_rst     <= alu_rst_d;
      op          <= op_d;
      a           <= a_d;
      b           <= b_d;
      issue_count <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_in_initiator.sv
// Directed bench for alu_in_initiator with RST_CYCLES=3; expectations are hand-derived cycle
// by cycle and checked with immediate assertions 1 time unit after each rising edge.
module tb_alu_in_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, cmd_valid, cmd_ready, ready;
  logic [2:0]  cmd_op, op;
  logic [7:0]  cmd_a, cmd_b, a, b;
  logic        valid, alu_rst, busy;
  logic [2:0]  fifo_level;
  logic [15:0] issue_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_in_initiator #(
    .ALU_IN_OP_WIDTH(8),
    .FIFO_DEPTH(4),
    .RST_CYCLES(3),
    .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ready(ready), .valid(valid), .alu_rst(alu_rst), .op(op), .a(a), .b(b),
    .busy(busy), .fifo_level(fifo_level), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb);
    cmd_valid = 1'b1;
    cmd_op    = o;
    cmd_a     = va;
    cmd_b     = vb;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_alu_rst"}, 32'(alu_rst), 32'd1);
    chk({tag, "_op_a_b"}, {13'd0, op, a, b}, 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_count"}, 32'(issue_count), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [2:0] t2_op [5];

  initial begin
    t2_op = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
    rst = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    ready = 1'b1;
    #12;
    chk_reset_state("reset");
    step();
    rst = 1'b1;

    // 1: single add
    push(3'd1, 8'h12, 8'h34);
    chk("t1_pre_valid", 32'(valid), 32'd0);
    chk("t1_pre_level", 32'(fifo_level), 32'd1);
    step();
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_bus", {13'd0, op, a, b}, {13'd0, 3'd1, 8'h12, 8'h34});
    chk("t1_busy_issue", 32'(busy), 32'd1);
    step();
    chk("t1_valid_low", 32'(valid), 32'd0);
    chk("t1_count", 32'(issue_count), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // 2: fill to full with enable low, hold a fifth command, then drain
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(t2_op[i], 8'h10 + 8'(i), 8'h20 + 8'(i));
    chk("t2_level_full", 32'(fifo_level), 32'd4);
    chk("t2_ready_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = t2_op[4]; cmd_a = 8'h14; cmd_b = 8'h24;
    step();
    chk("t2_level_held", 32'(fifo_level), 32'd4);
    chk("t2_no_issue", 32'(valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", 32'(valid), 32'd1);
      chk("t2_bus", {13'd0, op, a, b}, {13'd0, t2_op[i], 8'h10 + 8'(i), 8'h20 + 8'(i)});
      if (i == 0) chk("t2_ready_after_pop", 32'(cmd_ready), 32'd1);
      step();
      chk("t2_gap", 32'(valid), 32'd0);
      if (i == 0) begin
        chk("t2_level_refill", 32'(fifo_level), 32'd4);
        cmd_valid = 1'b0;
      end
    end
    chk("t2_level_empty", 32'(fifo_level), 32'd0);
    chk("t2_count", 32'(issue_count), 32'd6);

    // 3: ready stall
    ready = 1'b0;
    push(3'd4, 8'h03, 8'h05);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_stall_valid", 32'(valid), 32'd0);
    end
    chk("t3_stall_level", 32'(fifo_level), 32'd1);
    ready = 1'b1;
    step();
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_bus", {13'd0, op, a, b}, {13'd0, 3'd4, 8'h03, 8'h05});
    step();
    chk("t3_count", 32'(issue_count), 32'd7);

    // 4: rst_op pulse of 3 cycles then add
    push(3'd7, 8'hAA, 8'hBB);
    push(3'd1, 8'h05, 8'h06);
    chk("t4_rst_low0", 32'(alu_rst), 32'd0);
    chk("t4_bus", {12'd0, valid, op, a, b}, {12'd0, 1'b0, 3'd7, 8'h00, 8'h00});
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_rst_low", {30'd0, alu_rst, valid}, 32'd0);
      chk("t4_op_hold", 32'(op), 32'd7);
    end
    step();
    chk("t4_rst_high", {30'd0, alu_rst, valid}, 32'd2);
    chk("t4_count_pulse", 32'(issue_count), 32'd8);
    step();
    chk("t4_add_valid", 32'(valid), 32'd1);
    chk("t4_add_bus", {13'd0, op, a, b}, {13'd0, 3'd1, 8'h05, 8'h06});
    step();
    chk("t4_count", 32'(issue_count), 32'd9);

    // 5: enable gating
    enable = 1'b0;
    push(3'd2, 8'h0F, 8'hF0);
    push(3'd3, 8'hFF, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_quiet", 32'(valid), 32'd0);
    end
    chk("t5_level", 32'(fifo_level), 32'd2);
    enable = 1'b1;
    step();
    chk("t5_first", {12'd0, valid, op, a, b}, {12'd0, 1'b1, 3'd2, 8'h0F, 8'hF0});
    step();
    chk("t5_gap", 32'(valid), 32'd0);
    step();
    chk("t5_second", {12'd0, valid, op, a, b}, {12'd0, 1'b1, 3'd3, 8'hFF, 8'h01});
    step();
    chk("t5_count", 32'(issue_count), 32'd11);
    chk("t5_busy", 32'(busy), 32'd0);

    // 6: async reset mid RESET_PULSE, then mid ISSUE
    push(3'd7, 8'h00, 8'h00);
    push(3'd1, 8'h01, 8'h01);
    chk("t6_in_pulse", 32'(alu_rst), 32'd0);
    #2 rst = 1'b0;
    #1 chk_reset_state("t6_rst_pulse");
    rst = 1'b1;
    push(3'd1, 8'h21, 8'h43);
    step();
    chk("t6_in_issue", 32'(valid), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_state("t6_rst_issue");
    rst = 1'b1;
    push(3'd2, 8'h07, 8'h08);
    step();
    chk("t6_resume", {12'd0, valid, op, a, b}, {12'd0, 1'b1, 3'd2, 8'h07, 8'h08});
    step();
    chk("t6_resume_count", 32'(issue_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
